// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals for the fetch requester, the load/store requester and the shared memory port.
// The master modport is the arbiter's view. The slave modport is the view of the requesters and the memory.
interface mem_port_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   modport master (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata
   );

   modport slave (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_wstrb, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto a single memory port, with one transaction in flight.
// Data has priority over inst. After STARVE_MAX consecutive data grants while inst is waiting, inst is forced a grant.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state_r;
   state_t      next_state_s;
   logic        owner_data_r;
   logic [3:0]  starve_cnt_r;
   logic        mem_req_r;
   logic        mem_wr_r;
   logic [3:0]  mem_wstrb_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;

   logic        grant_s;
   logic        grant_inst_s;
   logic        addr_hs_s;
   logic        data_hs_s;

   // Next-state and handshake decode; handshakes outside their expected state are ignored.
   always_comb begin
      next_state_s = state_r;
      grant_s      = 1'b0;
      grant_inst_s = 1'b0;
      addr_hs_s    = 1'b0;
      data_hs_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.inst_req || bus.data_req) begin
               grant_s      = 1'b1;
               grant_inst_s = bus.inst_req && (!bus.data_req || (starve_cnt_r == STARVE_LIM));
               next_state_s = ADDR;
            end else begin
               next_state_s = IDLE;
            end
         end
         ADDR: begin
            if (bus.mem_addr_ok) begin
               addr_hs_s    = 1'b1;
               next_state_s = DATA;
            end else begin
               next_state_s = ADDR;
            end
         end
         DATA: begin
            if (bus.mem_data_ok) begin
               data_hs_s    = 1'b1;
               next_state_s = IDLE;
            end else begin
               next_state_s = DATA;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, owner and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         owner_data_r <= 1'b0;
         starve_cnt_r <= 4'd0;
      end else begin
         state_r <= next_state_s;
         if (grant_s) begin
            owner_data_r <= !grant_inst_s;
         end else begin
            owner_data_r <= owner_data_r;
         end
         if (grant_s && grant_inst_s) begin
            starve_cnt_r <= 4'd0;
         end else if (grant_s && bus.inst_req && (starve_cnt_r < STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end
   end

   // Registered memory-port request. The granted requester's fields are captured at grant time.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_r   <= 1'b0;
         mem_wr_r    <= 1'b0;
         mem_wstrb_r <= 4'b0000;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
      end else if (grant_s) begin
         mem_req_r <= 1'b1;
         if (grant_inst_s) begin
            mem_wr_r    <= 1'b0;
            mem_wstrb_r <= 4'b0000;
            mem_addr_r  <= bus.inst_addr;
            mem_wdata_r <= 32'd0;
         end else begin
            mem_wr_r    <= bus.data_wr;
            mem_wstrb_r <= bus.data_wstrb;
            mem_addr_r  <= bus.data_addr;
            mem_wdata_r <= bus.data_wdata;
         end
      end else if (addr_hs_s) begin
         mem_req_r <= 1'b0;
      end else begin
         mem_req_r <= mem_req_r;
      end
   end

   assign bus.mem_req   = mem_req_r;
   assign bus.mem_wr    = mem_wr_r;
   assign bus.mem_wstrb = mem_wstrb_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;

   // Requester responses are combinational so that accept and data arrive in the same cycle as the memory handshake.
   assign bus.inst_addr_ok = !rst && addr_hs_s && !owner_data_r;
   assign bus.data_addr_ok = !rst && addr_hs_s && owner_data_r;
   assign bus.inst_data_ok = !rst && data_hs_s && !owner_data_r;
   assign bus.data_data_ok = !rst && data_hs_s && owner_data_r;
   assign bus.inst_rdata   = owner_data_r ? 32'd0 : bus.mem_rdata;
   assign bus.data_rdata   = owner_data_r ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A transaction-level model is compared against the DUT every cycle.
// Literal expectations pin the grant order, latencies and captured values.
module tb_mem_port_arbiter;
   localparam int STARVE = 4;

   logic clk;
   logic rst;
   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_MAX(STARVE)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // model of the transaction in flight
   bit          m_busy = 1'b0;
   bit          m_addr_done = 1'b0;
   bit          m_owner_data = 1'b0;
   logic        m_wr = 1'b0;
   logic [3:0]  m_wstrb = 4'd0;
   logic [31:0] m_addr = 32'd0;
   logic [31:0] m_wdata = 32'd0;
   int          m_starve = 0;
   logic [15:0] glog = 16'd0;
   int          gcnt = 0;

   int n_iaok = 0, n_idok = 0, n_daok = 0, n_ddok = 0, n_mreq = 0;
   bit acc_i = 1'b0, acc_d = 1'b0;
   bit inst_hold = 1'b0, data_hold = 1'b0;

   logic        cap_wr, cap_idok, cap_ddok;
   logic [3:0]  cap_wstrb;
   logic [31:0] cap_addr, cap_wdata, cap_ir, cap_dr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Per-cycle comparison against the model, followed by advancing the model across the next edge.
   always @(negedge clk) begin
      logic e_req, e_iaok, e_daok, e_idok, e_ddok;
      logic [31:0] e_ir, e_dr;
      e_req  = m_busy && !m_addr_done;
      e_iaok = !rst && e_req && !m_owner_data && bus.mem_addr_ok;
      e_daok = !rst && e_req && m_owner_data && bus.mem_addr_ok;
      e_idok = !rst && m_busy && m_addr_done && !m_owner_data && bus.mem_data_ok;
      e_ddok = !rst && m_busy && m_addr_done && m_owner_data && bus.mem_data_ok;
      e_ir   = m_owner_data ? 32'd0 : bus.mem_rdata;
      e_dr   = m_owner_data ? bus.mem_rdata : 32'd0;
      chk("mem_req", 32'(bus.mem_req), 32'(e_req));
      chk("mem_wr", 32'(bus.mem_wr), 32'(m_wr));
      chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb));
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(e_iaok));
      chk("data_addr_ok", 32'(bus.data_addr_ok), 32'(e_daok));
      chk("inst_data_ok", 32'(bus.inst_data_ok), 32'(e_idok));
      chk("data_data_ok", 32'(bus.data_data_ok), 32'(e_ddok));
      chk("inst_rdata", bus.inst_rdata, e_ir);
      chk("data_rdata", bus.data_rdata, e_dr);
      n_iaok += int'(bus.inst_addr_ok);
      n_daok += int'(bus.data_addr_ok);
      n_idok += int'(bus.inst_data_ok);
      n_ddok += int'(bus.data_data_ok);
      n_mreq += int'(bus.mem_req);
      acc_i = bus.inst_addr_ok;
      acc_d = bus.data_addr_ok;
      if (rst) begin
         m_busy = 1'b0; m_addr_done = 1'b0; m_owner_data = 1'b0; m_starve = 0;
         m_wr = 1'b0; m_wstrb = 4'd0; m_addr = 32'd0; m_wdata = 32'd0;
      end else if (!m_busy) begin
         if (bus.inst_req || bus.data_req) begin
            m_busy = 1'b1;
            m_addr_done = 1'b0;
            m_owner_data = !(bus.inst_req && (!bus.data_req || m_starve == STARVE));
            if (m_owner_data) begin
               m_wr = bus.data_wr; m_wstrb = bus.data_wstrb;
               m_addr = bus.data_addr; m_wdata = bus.data_wdata;
               if (bus.inst_req && m_starve < STARVE) m_starve++;
            end else begin
               m_wr = 1'b0; m_wstrb = 4'd0; m_addr = bus.inst_addr; m_wdata = 32'd0;
               m_starve = 0;
            end
            glog = {glog[14:0], m_owner_data};
            gcnt++;
         end
      end else if (!m_addr_done) begin
         if (bus.mem_addr_ok) m_addr_done = 1'b1;
      end else if (bus.mem_data_ok) begin
         m_busy = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (acc_i && !inst_hold) bus.inst_req = 1'b0;
      if (acc_d && !data_hold) bus.data_req = 1'b0;
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!bus.mem_req && n < 40) begin
         step();
         n++;
      end
      chk("mem_req_wait", 32'(bus.mem_req), 32'd1);
   endtask

   task automatic serve(input int aw, input int dw, input logic [31:0] rd, output int waited);
      wait_req(waited);
      cap_addr = bus.mem_addr; cap_wr = bus.mem_wr; cap_wstrb = bus.mem_wstrb; cap_wdata = bus.mem_wdata;
      repeat (aw) step();
      bus.mem_addr_ok = 1'b1;
      step();
      bus.mem_addr_ok = 1'b0;
      repeat (dw) step();
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata = rd;
      #1;
      cap_idok = bus.inst_data_ok; cap_ddok = bus.data_data_ok;
      cap_ir = bus.inst_rdata; cap_dr = bus.data_rdata;
      step();
      bus.mem_data_ok = 1'b0;
      bus.mem_rdata = 32'd0;
   endtask

   initial begin
      int w, k0, k1, k2;
      rst = 1'b1;
      bus.inst_req = 1'b0; bus.inst_addr = 32'd0;
      bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_wstrb = 4'd0;
      bus.data_addr = 32'd0; bus.data_wdata = 32'd0;
      bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
      chk("reset_mem_addr", bus.mem_addr, 32'd0);
      step();

      // single fetch
      bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0000;
      k0 = n_idok;
      serve(0, 0, 32'h3C01_0000, w);
      chk("fetch_latency", 32'(w), 32'd1);
      chk("fetch_addr", cap_addr, 32'hBFC0_0000);
      chk("fetch_wr", 32'(cap_wr), 32'd0);
      chk("fetch_dok", 32'(cap_idok), 32'd1);
      chk("fetch_rdata", cap_ir, 32'h3C01_0000);
      step();
      chk("fetch_dok_pulses", 32'(n_idok - k0), 32'd1);

      // contention: data first, inst after one idle cycle
      gcnt = 0; glog = 16'd0;
      bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0040;
      bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b0011;
      bus.data_addr = 32'h1FAF_0000; bus.data_wdata = 32'h1234_5678;
      serve(0, 0, 32'h0, w);
      chk("cont_wstrb", 32'(cap_wstrb), 32'h3);
      chk("cont_addr", cap_addr, 32'h1FAF_0000);
      chk("cont_data_dok", 32'(cap_ddok), 32'd1);
      chk("cont_inst_dok", 32'(cap_idok), 32'd0);
      serve(0, 0, 32'hA5A5_0001, w);
      chk("cont_idle_gap", 32'(w), 32'd1);
      chk("cont_inst_wr", 32'(cap_wr), 32'd0);
      chk("cont_inst_wdata", cap_wdata, 32'd0);
      chk("cont_inst_rdata", cap_ir, 32'hA5A5_0001);
      chk("cont_order", {16'd0, glog}, 32'h2);
      chk("cont_grants", 32'(gcnt), 32'd2);

      // starvation: both held high continuously
      gcnt = 0; glog = 16'd0;
      inst_hold = 1'b1; data_hold = 1'b1;
      bus.inst_req = 1'b1; bus.data_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         serve(0, 0, 32'(i), w);
         chk("starve_gap", 32'(w), 32'd1);
      end
      bus.inst_req = 1'b0; bus.data_req = 1'b0;
      inst_hold = 1'b0; data_hold = 1'b0;
      chk("starve_grants", 32'(gcnt), 32'd10);
      chk("starve_order", {22'd0, glog[9:0]}, 32'b11110_11110);
      step();

      // slow memory
      k0 = n_ddok; k1 = n_daok; k2 = n_mreq;
      bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_wstrb = 4'b1111;
      bus.data_addr = 32'h0000_1000; bus.data_wdata = 32'h0;
      serve(3, 5, 32'hCAFE_F00D, w);
      step();
      chk("slow_req_cycles", 32'(n_mreq - k2), 32'd4);
      chk("slow_addr_ok", 32'(n_daok - k1), 32'd1);
      chk("slow_dok", 32'(n_ddok - k0), 32'd1);
      chk("slow_rdata", cap_dr, 32'hCAFE_F00D);

      // reset while in DATA
      bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0100;
      wait_req(w);
      bus.mem_addr_ok = 1'b1;
      step();
      bus.mem_addr_ok = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      k0 = n_idok;
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rst_late_dok", 32'(bus.inst_data_ok), 32'd0);
      step();
      bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'd0;
      chk("rst_no_dok", 32'(n_idok - k0), 32'd0);
      bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0200;
      serve(0, 0, 32'h0000_0055, w);
      chk("rst_after_addr", cap_addr, 32'h0000_0200);
      chk("rst_after_rdata", cap_ir, 32'h0000_0055);
      step();

      // spurious handshakes in IDLE and DATA
      bus.mem_data_ok = 1'b1; bus.mem_addr_ok = 1'b1;
      #1;
      chk("spur_idle_pulses", 32'({bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok}), 32'd0);
      step();
      bus.mem_data_ok = 1'b0; bus.mem_addr_ok = 1'b0;
      chk("spur_idle_req", 32'(bus.mem_req), 32'd0);
      k1 = n_daok;
      bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b0100;
      bus.data_addr = 32'h0000_0300; bus.data_wdata = 32'h0BAD_F00D;
      wait_req(w);
      bus.mem_addr_ok = 1'b1;
      step();
      bus.mem_addr_ok = 1'b1;
      #1;
      chk("spur_data_aok", 32'(bus.data_addr_ok), 32'd0);
      step();
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000_0077;
      #1;
      chk("spur_then_dok", 32'(bus.data_data_ok), 32'd1);
      step();
      bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'd0;
      chk("spur_aok_count", 32'(n_daok - k1), 32'd1);

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning max consecutive data grants while inst_req is pending before inst is forced a grant (range 1..15).
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port inst_req, input, 1, fetch request; held with inst_addr until inst_addr_ok.
REQ-005 SHALL have port inst_addr, input, 32, fetch address (read-only requester).
REQ-006 SHALL have port inst_addr_ok, output, 1, fetch address accepted.
REQ-007 SHALL have port inst_data_ok, output, 1, one-cycle pulse, inst_rdata valid.
REQ-008 SHALL have port inst_rdata, output, 32, fetch read data.
REQ-009 SHALL have port data_req, input, 1, load/store request; held with data_wr/wstrb/addr/wdata until data_addr_ok.
REQ-010 SHALL have ports data_wr (input, 1, write), data_wstrb (input, 4, byte enables), data_addr (input, 32), data_wdata (input, 32).
REQ-011 SHALL have ports data_addr_ok (output, 1), data_data_ok (output, 1, one-cycle pulse), data_rdata (output, 32).
REQ-012 SHALL have shared-port outputs mem_req (1), mem_wr (1), mem_wstrb (4), mem_addr (32), mem_wdata (32), all registered.
REQ-013 SHALL have shared-port inputs mem_addr_ok (1), mem_data_ok (1), mem_rdata (32).

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA; one transaction outstanding at most.
REQ-015 IDLE: if any request pending, SHALL grant one, latch owner and its request fields into mem_* registers, go ADDR next cycle; else stay IDLE.
REQ-016 Arbitration SHALL be data over inst, except inst wins when both pending and starve_cnt == STARVE_MAX.
REQ-017 starve_cnt SHALL increment (saturating at STARVE_MAX) on a data grant with inst_req high, clear to 0 on an inst grant, hold otherwise.
REQ-018 Inst grant SHALL drive mem_wr=0, mem_wstrb=4'b0000, mem_wdata=0.
REQ-019 ADDR: mem_req=1; on mem_addr_ok=1 SHALL assert owner's *_addr_ok combinationally in that same cycle, drop mem_req next cycle, go DATA.
REQ-020 DATA: mem_req=0; on mem_data_ok=1 SHALL pulse owner's *_data_ok in that same cycle, route mem_rdata to owner's *_rdata, return to IDLE.
REQ-021 *_rdata SHALL pass mem_rdata when owner matches, else 0; non-owner *_addr_ok/*_data_ok SHALL stay 0.
REQ-022 Minimum latency: req seen in IDLE cycle N -> mem_req high cycle N+1; addr_ok no earlier than N+1; data_ok no earlier than N+2.
REQ-023 Back-to-back: SHALL spend exactly one IDLE cycle between data_ok and next grant.
REQ-024 mem_addr_ok or mem_data_ok in a state not expecting it SHALL be ignored (no requester pulse, no transition).
REQ-025 Requester deasserting req before addr_ok is illegal; no recovery required.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, starve_cnt=0, mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, owner=inst.
REQ-027 Reset during ADDR or DATA SHALL abandon the transaction; a later mem_data_ok SHALL not produce any *_data_ok.
REQ-028 While rst=1 all *_addr_ok and *_data_ok outputs SHALL be 0.

Verification
REQ-029 Single fetch: inst_req=1, inst_addr=0xBFC00000, mem_addr_ok after 0 wait, mem_data_ok next cycle with 0x3C010000 -> mem_addr=0xBFC00000, mem_wr=0, inst_data_ok one pulse, inst_rdata=0x3C010000.
REQ-030 Contention: inst_req and data_req both high, data_wr=1, data_wstrb=4'b0011, data_addr=0x1FAF0000 -> data granted first, mem_wstrb=4'b0011; inst served next after one IDLE cycle.
REQ-031 Starvation: data_req held high continuously with inst_req high, STARVE_MAX=4 -> 4 data grants, 5th grant inst, starve_cnt back to 0.
REQ-032 Slow memory: mem_addr_ok delayed 3 cycles, mem_data_ok delayed 5 -> mem_req stable with unchanged fields for 4 cycles, single data_ok pulse, no spurious addr_ok.
REQ-033 Reset mid-op: rst pulsed for one cycle while in DATA, mem_data_ok arrives after -> no *_data_ok, all mem_* outputs 0, next request served normally.
REQ-034 Spurious handshake: mem_data_ok=1 in IDLE and mem_addr_ok=1 in DATA -> no state change, no requester pulse.
